mmcm_ps_responder: RTL and testbench

- Synthesizable responder for the MMCM dynamic phase-shift port (psen/psincdec/psdone).
- Sits on the responder side of that port, in place of the MMCM, in the woble_clk phase-shift path. Used in simulation and in hardware loopback of the write-strategy phase-shift controller.
- Models lock-up, the fixed psen-to-psdone latency, phase-step accumulation with wrap-around, and protocol-violation counting.

---
 rtl/mmcm_ps_if.sv | 22 ++
 rtl/mmcm_ps_responder.sv | 127 ++++++++++++
 tb/tb_mmcm_ps_responder.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mmcm_ps_if.sv
// Handshake signals of the MMCM dynamic phase-shift port (psen/psincdec/psdone)
// plus the responder's busy indication.
interface mmcm_ps_if;
    logic psen;
    logic psincdec;
    logic psdone;
    logic ps_busy;

    modport master (
        output psen,
        output psincdec,
        input  psdone,
        input  ps_busy
    );

    modport slave (
        input  psen,
        input  psincdec,
        output psdone,
        output ps_busy
    );
endinterface

// File: rtl/mmcm_ps_responder.sv
// Stand-in for the MMCM on the dynamic phase-shift port: lock-up delay, fixed
// psen-to-psdone latency, wrapping phase accumulator and violation counting.
module mmcm_ps_responder #(
    parameter int PS_LATENCY       = 12,
    parameter int STEPS_PER_PERIOD = 560,
    parameter int PHASE_W          = 12,
    parameter int LOCK_CYCLES      = 64
) (
    input  logic                      sys_clk,
    input  logic                      rst,
    mmcm_ps_if.slave                  ps,
    input  logic                      ps_clr,
    output logic                      locked,
    output logic [PHASE_W-1:0]        ps_phase,
    output logic signed [15:0]        ps_total,
    output logic [7:0]                ps_err_cnt
);

    localparam int LCW = $clog2(LOCK_CYCLES + 1);
    localparam int LAT_W = $clog2(PS_LATENCY + 1);
    localparam logic [LCW-1:0]     LOCK_LAST = LCW'(LOCK_CYCLES - 1);
    localparam logic [LAT_W-1:0]   LAT_LOAD  = LAT_W'(PS_LATENCY);
    localparam logic [PHASE_W-1:0] PH_MAX    = PHASE_W'(STEPS_PER_PERIOD - 1);

    typedef enum logic [1:0] {
        LOCKING = 2'd0,
        IDLE    = 2'd1,
        SHIFT   = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t           state;
    logic [LCW-1:0]   lock_cnt;
    logic [LAT_W-1:0] lat_cnt;
    logic             dir;
    logic             psdone_r;
    logic             busy_r;

    assign ps.psdone  = psdone_r;
    assign ps.ps_busy = busy_r;

    function automatic logic [PHASE_W-1:0] step_phase(
        input logic [PHASE_W-1:0] p,
        input logic               up
    );
        if (up)
            return (p == PH_MAX) ? '0 : p + PHASE_W'(1);
        else
            return (p == '0) ? PH_MAX : p - PHASE_W'(1);
    endfunction

    function automatic logic signed [15:0] sat_step(
        input logic signed [15:0] t,
        input logic               up
    );
        if (up)
            return (t == 16'sh7FFF) ? t : t + 16'sd1;
        else
            return (t == -16'sh8000) ? t : t - 16'sd1;
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state      <= LOCKING;
            lock_cnt   <= '0;
            lat_cnt    <= '0;
            dir        <= 1'b0;
            psdone_r   <= 1'b0;
            busy_r     <= 1'b0;
            locked     <= 1'b0;
            ps_phase   <= '0;
            ps_total   <= '0;
            ps_err_cnt <= '0;
        end else begin
            psdone_r <= 1'b0;
            case (state)
                LOCKING: begin
                    if (lock_cnt == LOCK_LAST) begin
                        locked <= 1'b1;
                        state  <= IDLE;
                    end else begin
                        lock_cnt <= lock_cnt + LCW'(1);
                    end
                end
                IDLE: begin
                    if (ps.psen) begin
                        dir     <= ps.psincdec;
                        lat_cnt <= LAT_LOAD;
                        busy_r  <= 1'b1;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    // Counter holds the edges still to go; the edge that sees 1 enters DONE.
                    if (lat_cnt == LAT_W'(1)) begin
                        state    <= DONE;
                        psdone_r <= 1'b1;
                        ps_phase <= step_phase(ps_phase, dir);
                        ps_total <= sat_step(ps_total, dir);
                    end else begin
                        lat_cnt <= lat_cnt - LAT_W'(1);
                    end
                end
                DONE: begin
                    busy_r <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= LOCKING;
            endcase

            if (ps.psen && (state != IDLE))
                ps_err_cnt <= sat_inc8(ps_err_cnt);

            // Placed last so a coincident clear overrides any update above.
            if (ps_clr) begin
                ps_phase   <= '0;
                ps_total   <= '0;
                ps_err_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_mmcm_ps_responder.sv
// Directed self-checking bench for mmcm_ps_responder with default parameters.
module tb_mmcm_ps_responder;

    localparam int LAT  = 12;
    localparam int STEP = 560;
    localparam int LOCK = 64;

    logic               sys_clk = 1'b0;
    logic               rst;
    logic               ps_clr;
    logic               locked;
    logic [11:0]        ps_phase;
    logic signed [15:0] ps_total;
    logic [7:0]         ps_err_cnt;

    int checks   = 0;
    int failures = 0;

    mmcm_ps_if ps_if ();

    mmcm_ps_responder #(
        .PS_LATENCY      (LAT),
        .STEPS_PER_PERIOD(STEP),
        .PHASE_W         (12),
        .LOCK_CYCLES     (LOCK)
    ) dut (
        .sys_clk   (sys_clk),
        .rst       (rst),
        .ps        (ps_if.slave),
        .ps_clr    (ps_clr),
        .locked    (locked),
        .ps_phase  (ps_phase),
        .ps_total  (ps_total),
        .ps_err_cnt(ps_err_cnt)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    // Issues one shift request and waits (bounded) for psdone, then returns to IDLE.
    task automatic shift_quiet(input bit inc, output bit got);
        ps_if.psen     = 1'b1;
        ps_if.psincdec = inc;
        step();
        ps_if.psen = 1'b0;
        got = 1'b0;
        for (int j = 0; j < 40 && !got; j++) begin
            step();
            if (ps_if.psdone) got = 1'b1;
        end
        step();
    endtask

    task automatic test_reset();
        int rise;
        int dones;
        rst = 1'b1;
        repeat (10) step();
        checks++;
        if ({ps_if.psdone, ps_if.ps_busy, locked} !== 3'b000) begin
            failures++;
            $display("FAIL reset_ctrl: got %b expected 000", {ps_if.psdone, ps_if.ps_busy, locked});
        end
        checks++;
        if (ps_phase !== 12'd0 || ps_total !== 16'sd0 || ps_err_cnt !== 8'd0) begin
            failures++;
            $display("FAIL reset_data: got phase=%0d total=%0d err=%0d expected 0 0 0",
                     ps_phase, ps_total, ps_err_cnt);
        end
        rst = 1'b0;
        rise = 0;
        dones = 0;
        for (int i = 1; i <= 100 && rise == 0; i++) begin
            if (i == 30) ps_if.psen = 1'b1;
            step();
            ps_if.psen = 1'b0;
            if (ps_if.psdone) dones++;
            if (locked === 1'b1) rise = i;
        end
        checks++;
        if (rise != LOCK) begin
            failures++;
            $display("FAIL lock_time: got %0d expected %0d", rise, LOCK);
        end
        checks++;
        if (ps_err_cnt !== 8'd1) begin
            failures++;
            $display("FAIL lock_err: got %0d expected 1", ps_err_cnt);
        end
        checks++;
        if (dones != 0) begin
            failures++;
            $display("FAIL lock_nodone: got %0d expected 0", dones);
        end
    endtask

    task automatic test_single_inc();
        ps_if.psen     = 1'b1;
        ps_if.psincdec = 1'b1;
        step();
        ps_if.psen     = 1'b0;
        ps_if.psincdec = 1'b0;
        checks++;
        if (ps_if.ps_busy !== 1'b1 || ps_if.psdone !== 1'b0) begin
            failures++;
            $display("FAIL inc_e0: got busy=%b done=%b expected 1 0", ps_if.ps_busy, ps_if.psdone);
        end
        for (int j = 1; j <= LAT + 1; j++) begin
            step();
            checks++;
            if (ps_if.psdone !== (j == LAT) || ps_if.ps_busy !== (j <= LAT)) begin
                failures++;
                $display("FAIL inc_cycle%0d: got done=%b busy=%b expected %b %b",
                         j, ps_if.psdone, ps_if.ps_busy, (j == LAT), (j <= LAT));
            end
            if (j == LAT) begin
                checks++;
                if (ps_phase !== 12'd1 || ps_total !== 16'sd1) begin
                    failures++;
                    $display("FAIL inc_value: got phase=%0d total=%0d expected 1 1", ps_phase, ps_total);
                end
            end
        end
    endtask

    task automatic test_clear();
        ps_clr = 1'b1;
        step();
        ps_clr = 1'b0;
        checks++;
        if (ps_phase !== 12'd0 || ps_total !== 16'sd0 || ps_err_cnt !== 8'd0 || locked !== 1'b1) begin
            failures++;
            $display("FAIL clear: got phase=%0d total=%0d err=%0d locked=%b expected 0 0 0 1",
                     ps_phase, ps_total, ps_err_cnt, locked);
        end
    endtask

    task automatic test_wrap();
        bit got;
        int dones;
        int exp_phase;
        shift_quiet(1'b0, got);
        checks++;
        if (!got || ps_phase !== 12'd559 || ps_total !== -16'sd1) begin
            failures++;
            $display("FAIL wrap_dec: got done=%b phase=%0d total=%0d expected 1 559 -1", got, ps_phase, ps_total);
        end
        dones = 0;
        for (int i = 0; i < 600; i++) begin
            shift_quiet(1'b1, got);
            if (got) dones++;
        end
        exp_phase = (559 + 600) % STEP;
        checks++;
        if (dones != 600) begin
            failures++;
            $display("FAIL wrap_dones: got %0d expected 600", dones);
        end
        checks++;
        if (ps_phase !== 12'(exp_phase) || ps_total !== 16'sd599) begin
            failures++;
            $display("FAIL wrap_inc: got phase=%0d total=%0d expected %0d 599", ps_phase, ps_total, exp_phase);
        end
    endtask

    task automatic test_violations();
        int dones;
        int late;
        ps_clr = 1'b1;
        step();
        ps_clr = 1'b0;
        ps_if.psen     = 1'b1;
        ps_if.psincdec = 1'b1;
        repeat (3) step();
        ps_if.psen = 1'b0;
        dones = 0;
        for (int j = 3; j <= LAT; j++) begin
            step();
            if (ps_if.psdone) dones++;
        end
        checks++;
        if (ps_if.psdone !== 1'b1 || ps_err_cnt !== 8'd2) begin
            failures++;
            $display("FAIL held3: got done=%b err=%0d expected 1 2", ps_if.psdone, ps_err_cnt);
        end
        ps_if.psen = 1'b1;
        step();
        ps_if.psen = 1'b0;
        checks++;
        if (ps_err_cnt !== 8'd3 || ps_if.ps_busy !== 1'b0) begin
            failures++;
            $display("FAIL coincident: got err=%0d busy=%b expected 3 0", ps_err_cnt, ps_if.ps_busy);
        end
        late = 0;
        repeat (20) begin
            step();
            if (ps_if.psdone || ps_if.ps_busy) late++;
        end
        checks++;
        if (dones != 1 || late != 0) begin
            failures++;
            $display("FAIL noshift: got dones=%0d late=%0d expected 1 0", dones, late);
        end
    endtask

    task automatic test_clear_sat();
        int waited;
        ps_if.psen     = 1'b1;
        ps_if.psincdec = 1'b1;
        step();
        ps_if.psen = 1'b0;
        repeat (LAT - 1) step();
        ps_clr = 1'b1;
        step();
        ps_clr = 1'b0;
        checks++;
        if (ps_if.psdone !== 1'b1 || ps_phase !== 12'd0 || ps_total !== 16'sd0 || ps_err_cnt !== 8'd0) begin
            failures++;
            $display("FAIL clr_done: got done=%b phase=%0d total=%0d err=%0d expected 1 0 0 0",
                     ps_if.psdone, ps_phase, ps_total, ps_err_cnt);
        end
        step();
        ps_if.psen = 1'b1;
        repeat (350) step();
        ps_if.psen = 1'b0;
        waited = 0;
        while (ps_if.ps_busy && waited < 40) begin
            step();
            waited++;
        end
        checks++;
        if (ps_err_cnt !== 8'd255 || ps_if.ps_busy !== 1'b0) begin
            failures++;
            $display("FAIL err_sat: got err=%0d busy=%b expected 255 0", ps_err_cnt, ps_if.ps_busy);
        end
    endtask

    task automatic test_reset_mid();
        int rise;
        int dones;
        bit got;
        ps_clr = 1'b1;
        step();
        ps_clr = 1'b0;
        ps_if.psen     = 1'b1;
        ps_if.psincdec = 1'b1;
        step();
        ps_if.psen = 1'b0;
        repeat (5) step();
        rst = 1'b1;
        #1;
        checks++;
        if ({ps_if.psdone, ps_if.ps_busy, locked} !== 3'b000 || ps_phase !== 12'd0 ||
            ps_total !== 16'sd0 || ps_err_cnt !== 8'd0) begin
            failures++;
            $display("FAIL midrst_out: got done=%b busy=%b locked=%b phase=%0d total=%0d err=%0d expected all 0",
                     ps_if.psdone, ps_if.ps_busy, locked, ps_phase, ps_total, ps_err_cnt);
        end
        repeat (3) step();
        rst = 1'b0;
        rise = 0;
        dones = 0;
        for (int i = 1; i <= 100 && rise == 0; i++) begin
            step();
            if (ps_if.psdone) dones++;
            if (locked === 1'b1) rise = i;
        end
        checks++;
        if (rise != LOCK || dones != 0) begin
            failures++;
            $display("FAIL relock: got rise=%0d dones=%0d expected %0d 0", rise, dones, LOCK);
        end
        shift_quiet(1'b1, got);
        checks++;
        if (!got || ps_phase !== 12'd1 || ps_total !== 16'sd1) begin
            failures++;
            $display("FAIL post_relock: got done=%b phase=%0d total=%0d expected 1 1 1", got, ps_phase, ps_total);
        end
    endtask

    initial begin
        rst            = 1'b1;
        ps_clr         = 1'b0;
        ps_if.psen     = 1'b0;
        ps_if.psincdec = 1'b0;
        test_reset();
        test_single_inc();
        test_clear();
        test_wrap();
        test_violations();
        test_clear_sat();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
